// File: rtl/ddr_req_queue_if.sv
// Host request channel into the DDR request queue: valid/ready handshake
// carrying one {addr, write data, direction} request per transfer.
interface ddr_req_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic        req_rw;

  modport master (
    output req_valid, req_addr, req_data, req_rw,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_rw,
    output req_ready
  );
endinterface

// File: rtl/ddr_req_queue.sv
// In-order request FIFO plus issue sequencer; issues the head one edge after it lands in an empty queue.
// Backpressure: req_ready is low while full (no same-edge bypass); issue stalls on dev_busy and the post-issue gap.
module ddr_req_queue #(
  parameter int DEPTH   = 8,
  parameter int MIN_GAP = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clock_n,
  input  logic                     reset_n,
  ddr_req_queue_if.slave           req,
  input  logic                     dev_busy,
  output logic                     act_cmd,
  output logic [31:0]              phys_addr,
  output logic [63:0]              data_wr,
  output logic                     rw,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [CNT_W-1:0]         issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic        rw;
  } req_t;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          ready_q;
  logic [GW-1:0] gap_cnt;
  state_t        state;
  logic          push;
  logic          pop;
  req_t          head;
  req_t          wr_ent;

  assign req.req_ready = ready_q;
  assign q_count       = count;
  assign head          = mem[rd_ptr];
  assign wr_ent        = '{addr: req.req_addr, data: req.req_data, rw: req.req_rw};

  always_comb begin
    push      = req.req_valid && ready_q;
    pop       = (state == IDLE) && (count != '0) && !dev_busy;
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock_n) begin
    if (push) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  always_ff @(posedge clock_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_q    <= 1'b0;
      state      <= IDLE;
      gap_cnt    <= '0;
      act_cmd    <= 1'b0;
      phys_addr  <= '0;
      data_wr    <= '0;
      rw         <= 1'b0;
      issued_cnt <= '0;
    end else begin
      count   <= count_nxt;
      // Registered full flag: a pop on the full edge only reopens the next edge.
      ready_q <= (count_nxt != (AW+1)'(DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      case (state)
        IDLE: begin
          act_cmd <= 1'b0;
          if (pop) begin
            act_cmd    <= 1'b1;
            phys_addr  <= head.addr;
            data_wr    <= head.data;
            rw         <= head.rw;
            rd_ptr     <= rd_ptr + 1'b1;
            issued_cnt <= issued_cnt + 1'b1;
            gap_cnt    <= GW'(MIN_GAP);
            state      <= GAP;
          end
        end
        GAP: begin
          act_cmd <= 1'b0;
          // Leaving on the edge that would count down to zero keeps pulses MIN_GAP+1 edges apart.
          if (gap_cnt <= GW'(1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          act_cmd <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_req_queue.sv
// Directed bench for ddr_req_queue: reset, single issue, gap spacing, busy stall,
// full-with-pop, and mid-operation reset, all against hand-computed values.
module tb_ddr_req_queue;
  localparam int DEPTH   = 8;
  localparam int MIN_GAP = 8;
  localparam int CNT_W   = 16;

  logic        clock_n  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        dev_busy = 1'b0;
  logic        act_cmd;
  logic [31:0] phys_addr;
  logic [63:0] data_wr;
  logic        rw;
  logic [3:0]  q_count;
  logic [15:0] issued_cnt;

  ddr_req_queue_if req();

  ddr_req_queue #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
    .clock_n    (clock_n),
    .reset_n    (reset_n),
    .req        (req),
    .dev_busy   (dev_busy),
    .act_cmd    (act_cmd),
    .phys_addr  (phys_addr),
    .data_wr    (data_wr),
    .rw         (rw),
    .q_count    (q_count),
    .issued_cnt (issued_cnt)
  );

  always #5 clock_n = ~clock_n;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int          p_cyc [$];
  logic [96:0] p_ent [$];
  logic [96:0] exp_ent [9];

  always @(posedge clock_n) cyc++;

  always @(negedge clock_n) begin
    if (act_cmd === 1'b1) begin
      p_cyc.push_back(cyc);
      p_ent.push_back({phys_addr, data_wr, rw});
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_n);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [63:0] d, input logic r);
    req.req_valid = 1'b1;
    req.req_addr  = a;
    req.req_data  = d;
    req.req_rw    = r;
    step();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int left;
    left = budget;
    while (p_cyc.size() < n && left > 0) begin
      step();
      left--;
    end
    chk("pulse_count", p_cyc.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req.req_valid = 1'b1;
    req.req_addr  = 32'hdead_beef;
    req.req_data  = 64'h1234_5678_9abc_def0;
    req.req_rw    = 1'b1;

    // 1. reset hold with a pending request
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_act", act_cmd, 1'b0);
      chk("rst_qcount", q_count, 4'd0);
      chk("rst_ready", req.req_ready, 1'b0);
    end
    reset_n       = 1'b1;
    req.req_valid = 1'b0;
    step();
    chk("post_rst_ready", req.req_ready, 1'b1);
    chk("post_rst_qcount", q_count, 4'd0);
    chk("post_rst_issued", issued_cnt, 16'd0);
    chk("post_rst_outs", {phys_addr, data_wr, rw}, 97'd0);

    // 2. single write
    drive(32'h2000_a011, 64'h0000_a011_0000_a011, 1'b1);
    req.req_valid = 1'b0;
    chk("single_q_after_push", q_count, 4'd1);
    chk("single_act_early", act_cmd, 1'b0);
    step();
    chk("single_act", act_cmd, 1'b1);
    chk("single_addr", phys_addr, 32'h2000_a011);
    chk("single_data", data_wr, 64'h0000_a011_0000_a011);
    chk("single_rw", rw, 1'b1);
    chk("single_issued", issued_cnt, 16'd1);
    chk("single_q_empty", q_count, 4'd0);
    step();
    chk("single_act_one_cycle", act_cmd, 1'b0);
    chk("single_addr_hold", phys_addr, 32'h2000_a011);
    repeat (10) step();
    p_cyc.delete();
    p_ent.delete();

    // 3. gap spacing across three back-to-back pushes
    exp_ent[0] = {32'h2000_a011, 64'h0000_a011_0000_a011, 1'b1};
    exp_ent[1] = {32'h2000_a051, 64'h0000_a051_0000_a051, 1'b1};
    exp_ent[2] = {32'h2000_a011, 64'h0000_0000_0000_0000, 1'b0};
    for (int i = 0; i < 3; i++) drive(exp_ent[i][96:65], exp_ent[i][64:1], exp_ent[i][0]);
    req.req_valid = 1'b0;
    wait_pulses(3, 40);
    for (int i = 0; i < 3 && i < p_cyc.size(); i++) begin
      chk($sformatf("gap_entry%0d", i), p_ent[i], exp_ent[i]);
      if (i > 0) chk($sformatf("gap_spacing%0d", i), p_cyc[i] - p_cyc[i-1], MIN_GAP + 1);
    end
    chk("gap_issued", issued_cnt, 16'd4);
    repeat (10) step();
    p_cyc.delete();
    p_ent.delete();

    // 4. busy stall fills the queue
    dev_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_ent[i] = {32'h3000_0000 | 32'(i), 32'hd00d_0000 | 32'(i), 32'(i), i[0]};
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("busy_ready%0d", i), req.req_ready, 1'b1);
      drive(exp_ent[i][96:65], exp_ent[i][64:1], exp_ent[i][0]);
    end
    chk("busy_full_q", q_count, 4'd8);
    chk("busy_full_ready", req.req_ready, 1'b0);
    drive(exp_ent[8][96:65], exp_ent[8][64:1], exp_ent[8][0]);
    chk("busy_9th_refused", q_count, 4'd8);
    chk("busy_no_act", p_cyc.size(), 0);

    // 5. full queue with issue on the same edge as a push attempt
    dev_busy = 1'b0;
    step();
    chk("full_pop_act", act_cmd, 1'b1);
    chk("full_pop_q", q_count, 4'd7);
    chk("full_pop_ready", req.req_ready, 1'b1);
    chk("full_pop_addr", phys_addr, exp_ent[0][96:65]);
    chk("full_pop_issued", issued_cnt, 16'd5);
    step();
    req.req_valid = 1'b0;
    chk("full_refill_q", q_count, 4'd8);
    chk("full_refill_act", act_cmd, 1'b0);
    wait_pulses(9, 100);
    for (int i = 0; i < 9 && i < p_cyc.size(); i++) begin
      chk($sformatf("drain_entry%0d", i), p_ent[i], exp_ent[i]);
      if (i > 0) chk($sformatf("drain_spacing%0d", i), p_cyc[i] - p_cyc[i-1], MIN_GAP + 1);
    end
    chk("drain_issued", issued_cnt, 16'd13);
    repeat (10) step();
    chk("drain_q_empty", q_count, 4'd0);

    // 6. reset while entries are queued and a gap is running
    for (int i = 0; i < 5; i++) drive(32'h4000_0000 | 32'(i), 64'(i), 1'b1);
    req.req_valid = 1'b0;
    chk("mid_q_before", q_count, 4'd4);
    reset_n = 1'b0;
    step();
    chk("mid_rst_q", q_count, 4'd0);
    chk("mid_rst_act", act_cmd, 1'b0);
    chk("mid_rst_issued", issued_cnt, 16'd0);
    chk("mid_rst_addr", phys_addr, 32'd0);
    reset_n = 1'b1;
    step();
    chk("mid_rel_ready", req.req_ready, 1'b1);
    drive(32'h5555_0001, 64'hcafe_f00d_0000_0001, 1'b0);
    req.req_valid = 1'b0;
    chk("mid_push_q", q_count, 4'd1);
    step();
    chk("mid_issue_act", act_cmd, 1'b1);
    chk("mid_issue_addr", phys_addr, 32'h5555_0001);
    chk("mid_issue_data", data_wr, 64'hcafe_f00d_0000_0001);
    chk("mid_issue_rw", rw, 1'b0);
    chk("mid_issue_cnt", issued_cnt, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ddr_req_queue.md
Name: ddr_req_queue

Overview:
- Request buffer and issue sequencer directly upstream of the burst activate/data stages.
- Accepts host read/write requests over a valid/ready handshake and stores them in order in a FIFO.
- Issues each request as a one-cycle act_cmd pulse with stable address, write data and rw fields.
- Issue is throttled by dev_busy from the DDR controller and by a minimum inter-command gap.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- MIN_GAP, 8, idle cycles forced after each act_cmd pulse before the next issue may occur.
- CNT_W, 16, width of the issued-request counter.

Ports:
- clock_n  in  1  design clock; all logic on posedge.
- reset_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  host request present.
- req_ready  out  1  queue can accept; equals !full.
- req_addr  in  32  physical address.
- req_data  in  64  write data; ignored for reads.
- req_rw  in  1  1 = WRITE, 0 = READ.
- dev_busy  in  1  controller busy (init/MRS/refresh/burst in progress).
- act_cmd  out  1  one-cycle issue strobe to the activate and data stages.
- phys_addr  out  32  issued address.
- data_wr  out  64  issued write data.
- rw  out  1  issued direction.
- q_count  out  $clog2(DEPTH)+1  current occupancy.
- issued_cnt  out  CNT_W  total requests issued; wraps modulo 2^CNT_W.

Behaviour:
Reset (reset_n low at a posedge):
- All outputs go to 0; req_ready = 1 once out of reset.
- FIFO pointers and occupancy cleared; state = IDLE; gap counter = 0.
- A reset mid-operation discards all queued entries and aborts any gap in progress.

FIFO:
- Push when req_valid && req_ready at a posedge; the entry is {req_addr, req_data, req_rw}.
- Pop occurs on the issue edge.
- Pointers wrap modulo DEPTH.
- At full, req_ready = 0 even if a pop occurs on the same edge; there is no bypass.
- Simultaneous push and pop when not full: occupancy is unchanged and both operations take effect.

State machine:
- IDLE: issue at a posedge when occupancy > 0 && dev_busy == 0. On that edge:
  - act_cmd <= 1;
  - phys_addr/data_wr/rw <= head entry;
  - pop;
  - issued_cnt += 1;
  - gap counter <= MIN_GAP;
  - go to GAP.
- GAP:
  - act_cmd <= 0; decrement the gap counter each cycle.
  - When the counter reaches 0, go to IDLE.
  - If MIN_GAP = 0, go directly to IDLE on the edge after the issue.
  - dev_busy is ignored during GAP.
- Back-to-back spacing: consecutive act_cmd pulses are at least MIN_GAP+1 cycles apart, edge to edge.

Output timing:
- act_cmd is high for exactly one cycle per issue.
- phys_addr/data_wr/rw hold their values until the next issue; they are not cleared after the pulse.
- Latency: an entry pushed into an empty queue at edge k is issued at edge k+1 (act_cmd visible in the cycle after k+1), provided state is IDLE and dev_busy = 0 at edge k+1.

dev_busy:
- dev_busy high in IDLE stalls issue indefinitely.
- Pushes continue until full.
- Issue resumes on the first edge where dev_busy is sampled low.

Ordering and counters:
- Strict FIFO order; there is no read/write reordering.
- issued_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
1. Reset hold: reset_n = 0 for 5 cycles with req_valid = 1 -> act_cmd = 0, q_count = 0, req_ready = 0 during reset; req_ready = 1 on the first cycle after release.
2. Single write: push addr 32'h2000a011, data 64'h0000a0110000a011, rw = 1 with dev_busy = 0 -> act_cmd pulses on the next edge; phys_addr/data_wr/rw match; issued_cnt = 1; q_count returns to 0.
3. Gap spacing: push three requests back-to-back (2000a011 W, 2000a051 W, 2000a011 R) -> act_cmd edges are 9 cycles apart (MIN_GAP = 8); outputs appear in push order.
4. Busy stall: dev_busy = 1, push 8 requests -> q_count = 8, req_ready = 0, no act_cmd; a 9th push is refused. Drop dev_busy -> first issue on the next edge, then spaced drain of all 8 entries.
5. Full with simultaneous pop: queue full and issue on edge e while req_valid = 1 -> push refused at e; accepted at e+1 and q_count = 8 again.
6. Mid-operation reset: 4 entries queued and GAP active, assert reset_n = 0 for one edge -> q_count = 0, state IDLE; a subsequent push issues with 1-cycle latency and no residual gap.
